// File: rtl/gate_issue_scheduler.sv
// gate_issue_scheduler
// Buffers Clifford gate instructions (H / Phase / CNOT) from the gate-list
// loader. It issues them one at a time to the canonical-form engine and the
// global-phase engine. The next gate is released only after both engines
// report that the current gate is finished.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   start               one-cycle pulse that begins a run (honoured in IDLE only)
//   gate_valid_in       loader presents a gate instruction
//   gate_ready_out      queue can accept (registered, ~full)
//   gate_type_in        0 H, 1 Phase, 2 CNOT, 3 illegal
//   qubit_pos_in        target (H/P) or control (CNOT)
//   qubit_pos2_in       CNOT target
//   last_gate_in        final gate of the circuit
//   issue_start         one-cycle start pulse to both engines
//   gate_type, qubit_pos, qubit_pos2
//                       issued gate, held until the next issue
//   gp_ready            global-phase engine finished the current gate
//   canon_done          canonical engine finished the current gate
//   busy                high in every state except IDLE
//   run_done            one-cycle pulse at the end of a run
//   gates_issued        gates completed in the current run
//   count_h_issued      Hadamards completed in the current run
//   error               sticky: illegal gate, bad position or watchdog expiry
//   fifo_count          queue occupancy
//   wd_timeout          sticky watchdog flag (only with GATE_SEQ_WATCHDOG_EN)
//
// Optional feature macro: GATE_SEQ_WATCHDOG_EN
//   Bounds the WAIT state to WD_CYCLES cycles. On expiry the gate is abandoned
//   and the run ends.
module gate_issue_scheduler #(
  parameter int num_qubit  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int WD_CYCLES  = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          gate_valid_in,
  output logic                          gate_ready_out,
  input  logic [1:0]                    gate_type_in,
  input  logic [31:0]                   qubit_pos_in,
  input  logic [31:0]                   qubit_pos2_in,
  input  logic                          last_gate_in,
  output logic                          issue_start,
  output logic [1:0]                    gate_type,
  output logic [31:0]                   qubit_pos,
  output logic [31:0]                   qubit_pos2,
  input  logic                          gp_ready,
  input  logic                          canon_done,
  output logic                          busy,
  output logic                          run_done,
  output logic [31:0]                   gates_issued,
  output logic [31:0]                   count_h_issued,
  output logic                          error,
`ifdef GATE_SEQ_WATCHDOG_EN
  output logic                          wd_timeout,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]  gtype;
    logic [31:0] pos;
    logic [31:0] pos2;
    logic        last;
  } entry_t;

  state_t          state, state_next;
  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q, count_next;
  logic            ready_q;
  logic            push, pop;
  logic            head_legal;
  logic            load_gate, illegal_pop, gate_complete;
  logic            cur_last;
  logic            seen_gp, seen_cu;
`ifdef GATE_SEQ_WATCHDOG_EN
  logic [31:0]     wd_cnt;
  logic            wd_expire;
`endif

  assign gate_ready_out = ready_q;
  assign fifo_count     = count_q;

  // The ready flag comes from the registered count. A push offered while full
  // is dropped even when a pop happens in the same cycle.
  assign push       = gate_valid_in & ready_q;
  assign count_next = count_q + CW'(push) - CW'(pop);
  assign head       = mem[rd_ptr];

  // A position must be inside the register. A CNOT also needs two distinct qubits.
  always_comb begin
    head_legal = (head.gtype != 2'd3) && (head.pos < 32'(num_qubit));
    if (head.gtype == 2'd2)
      head_legal = head_legal && (head.pos2 < 32'(num_qubit)) && (head.pos2 != head.pos);
  end

  // NOTE: queue storage has no reset; the pointers and the count define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{gate_type_in, qubit_pos_in, qubit_pos2_in, last_gate_in};
  end

  // NOTE: all state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // infer a latch.
  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    load_gate     = 1'b0;
    illegal_pop   = 1'b0;
    gate_complete = 1'b0;
    issue_start   = 1'b0;
    run_done      = 1'b0;
    busy          = (state != S_IDLE);
`ifdef GATE_SEQ_WATCHDOG_EN
    wd_expire     = 1'b0;
`endif
    unique case (state)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (head_legal) begin
            load_gate  = 1'b1;
            state_next = S_ISSUE;
          end else begin
            illegal_pop = 1'b1;
            if (head.last) state_next = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        issue_start = 1'b1;
        state_next  = S_WAIT;
      end
      S_WAIT: begin
        // A live level counts as well as a remembered one, so completion
        // can occur in the same cycle as the second report.
        if ((seen_gp | gp_ready) & (seen_cu | canon_done)) begin
          gate_complete = 1'b1;
          state_next    = cur_last ? S_DONE : S_FETCH;
        end
`ifdef GATE_SEQ_WATCHDOG_EN
        else if (wd_cnt == 32'(WD_CYCLES - 1)) begin
          wd_expire  = 1'b1;
          state_next = S_DONE;
        end
`endif
      end
      S_DONE: begin
        run_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      ready_q        <= 1'b1;
      gate_type      <= '0;
      qubit_pos      <= '0;
      qubit_pos2     <= '0;
      cur_last       <= 1'b0;
      seen_gp        <= 1'b0;
      seen_cu        <= 1'b0;
      gates_issued   <= '0;
      count_h_issued <= '0;
      error          <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
      ready_q <= (count_next != CW'(FIFO_DEPTH));

      if (state == S_IDLE && start) begin
        gates_issued   <= '0;
        count_h_issued <= '0;
        error          <= 1'b0;
      end

      if (load_gate) begin
        gate_type  <= head.gtype;
        qubit_pos  <= head.pos;
        qubit_pos2 <= head.pos2;
        cur_last   <= head.last;
      end
      if (illegal_pop) error <= 1'b1;

      // During ISSUE the engines still show the previous gate, so their
      // reports are ignored and the flags are cleared.
      if (state == S_ISSUE) begin
        seen_gp <= 1'b0;
        seen_cu <= 1'b0;
      end else if (state == S_WAIT) begin
        seen_gp <= seen_gp | gp_ready;
        seen_cu <= seen_cu | canon_done;
      end

      if (gate_complete) begin
        gates_issued <= gates_issued + 32'd1;
        if (gate_type == 2'd0) count_h_issued <= count_h_issued + 32'd1;
      end
`ifdef GATE_SEQ_WATCHDOG_EN
      if (wd_expire) error <= 1'b1;
`endif
    end
  end

`ifdef GATE_SEQ_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt     <= '0;
      wd_timeout <= 1'b0;
    end else begin
      if (state == S_ISSUE)     wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + 32'd1;
      if (state == S_IDLE && start) wd_timeout <= 1'b0;
      else if (wd_expire)           wd_timeout <= 1'b1;
    end
  end
`endif

endmodule
